// File: rtl/lowampa_bq_coeff_loader.sv
// Wishbone master that broadcasts one biquad coefficient set into selected low-amplitude trigger chains.
// Optional readback-verify of every coefficient write: define LOWAMPA_BQ_LOADER_READBACK_EN.
module lowampa_bq_coeff_loader #(
  parameter int          NCOEFF     = 8,
  parameter logic [7:0]  COEF_BASE  = 8'h00,
  parameter logic [7:0]  UPDATE_ADR = 8'h80,
  parameter int          TIMEOUT    = 255,
  parameter int          RTY_LIMIT  = 3,
  localparam int         IW         = (NCOEFF > 1) ? $clog2(NCOEFF) : 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          start_i,
  input  logic [7:0]    chan_mask_i,
  input  logic          coef_we_i,
  input  logic [IW-1:0] coef_idx_i,
  input  logic [31:0]   coef_dat_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [2:0]    err_chan_o,
  output logic [2:0]    err_code_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [21:0]   wb_adr_o,
  output logic [31:0]   wb_dat_o,
  output logic [3:0]    wb_sel_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  input  logic [31:0]   wb_dat_i
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_COMMIT, S_FINISH, S_ABORT} state_t;
  typedef enum logic [1:0] {K_WR, K_RD, K_CM} kind_t;

  state_t        state, state_n;
  kind_t         kind_q;
  logic [7:0]    mask_q;
  logic [2:0]    chan_q;
  logic [IW-1:0] kidx;
  logic          again_q;
  logic [7:0]    rty_cnt;
  logic [15:0]   tmo_cnt;
  logic [31:0]   coef_mem [NCOEFF];

  logic          xfer, last_k, rty_ok;
  logic [2:0]    code_n;
  logic [7:0]    hi_mask, loc;
  logic [31:0]   wdat;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) lowest = 3'(i);
  endfunction

  assign xfer    = (state == S_ISSUE) || (state == S_WAIT) || (state == S_COMMIT);
  assign last_k  = (32'(kidx) == 32'(NCOEFF - 1));
  // channels above the current one that are still to be loaded
  assign hi_mask = mask_q & ~((8'd2 << chan_q) - 8'd1);
  assign loc     = (kind_q == K_CM) ? UPDATE_ADR : COEF_BASE + 8'({kidx, 2'b00});
  assign wdat    = (kind_q == K_CM) ? 32'h1 : coef_mem[kidx];

  always_comb begin
    state_n = state;
    code_n  = 3'd0;
    rty_ok  = 1'b0;
    case (state)
      S_IDLE:
        if (start_i) state_n = (chan_mask_i == 8'h00) ? S_FINISH : S_ISSUE;
      S_ISSUE, S_COMMIT, S_WAIT: begin
        if (wb_err_i) begin
          state_n = S_ABORT; code_n = 3'd1;
        end else if (wb_rty_i) begin
          if (rty_cnt == 8'(RTY_LIMIT)) begin
            state_n = S_ABORT; code_n = 3'd3;
          end else begin
            state_n = S_GAP; rty_ok = 1'b1;
          end
        end else if (wb_ack_i) begin
          if (kind_q == K_RD && wb_dat_i != wdat) begin
            state_n = S_ABORT; code_n = 3'd4;
          end else begin
            state_n = S_GAP;
          end
        end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
          state_n = S_ABORT; code_n = 3'd2;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_GAP: begin
        if (again_q) state_n = (kind_q == K_CM) ? S_COMMIT : S_ISSUE;
        else begin
          case (kind_q)
`ifdef LOWAMPA_BQ_LOADER_READBACK_EN
            K_WR:    state_n = S_ISSUE;
`else
            K_WR:    state_n = last_k ? S_COMMIT : S_ISSUE;
`endif
            K_RD:    state_n = last_k ? S_COMMIT : S_ISSUE;
            default: state_n = (hi_mask == 8'h00) ? S_FINISH : S_ISSUE;
          endcase
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      kind_q     <= K_WR;
      mask_q     <= 8'h00;
      chan_q     <= 3'd0;
      kidx       <= '0;
      again_q    <= 1'b0;
      rty_cnt    <= 8'd0;
      tmo_cnt    <= 16'd0;
      err_o      <= 1'b0;
      err_chan_o <= 3'd0;
      err_code_o <= 3'd0;
      for (int i = 0; i < NCOEFF; i++) coef_mem[i] <= 32'h0;
    end else begin
      state   <= state_n;
      tmo_cnt <= xfer ? tmo_cnt + 16'd1 : 16'd0;
      if (state == S_IDLE && coef_we_i && 32'(coef_idx_i) < 32'(NCOEFF))
        coef_mem[coef_idx_i] <= coef_dat_i;
      if (state == S_IDLE && start_i) begin
        mask_q     <= chan_mask_i;
        chan_q     <= lowest(chan_mask_i);
        kidx       <= '0;
        kind_q     <= K_WR;
        again_q    <= 1'b0;
        rty_cnt    <= 8'd0;
        err_o      <= 1'b0;
        err_chan_o <= 3'd0;
        err_code_o <= 3'd0;
      end
      if (xfer && rty_ok) begin
        again_q <= 1'b1;
        rty_cnt <= rty_cnt + 8'd1;
      end
      if (xfer && state_n == S_ABORT) begin
        err_o      <= 1'b1;
        err_code_o <= code_n;
        err_chan_o <= chan_q;
      end
      // a retried transfer keeps its position; anything else advances and re-arms the retry budget
      if (state == S_GAP) begin
        if (again_q) again_q <= 1'b0;
        else begin
          rty_cnt <= 8'd0;
          case (kind_q)
            K_WR: begin
`ifdef LOWAMPA_BQ_LOADER_READBACK_EN
              kind_q <= K_RD;
`else
              if (last_k) kind_q <= K_CM;
              else kidx <= kidx + IW'(1);
`endif
            end
            K_RD: begin
              if (last_k) kind_q <= K_CM;
              else begin
                kind_q <= K_WR;
                kidx   <= kidx + IW'(1);
              end
            end
            default: begin
              chan_q <= lowest(hi_mask);
              kidx   <= '0;
              kind_q <= K_WR;
            end
          endcase
        end
      end
    end
  end

  // an empty mask still reports busy alongside its done pulse
  assign busy_o   = (state != S_IDLE) && !(state == S_FINISH && mask_q != 8'h00);
  assign done_o   = (state == S_FINISH);
  assign wb_cyc_o = xfer;
  assign wb_stb_o = xfer;
  assign wb_we_o  = xfer && (kind_q != K_RD);
  assign wb_adr_o = xfer ? {9'b0, chan_q, 2'b00, loc} : 22'h0;
  assign wb_dat_o = xfer ? wdat : 32'h0;
  assign wb_sel_o = xfer ? 4'hF : 4'h0;

endmodule

// File: tb/tb_lowampa_bq_coeff_loader.sv
// Directed bench for lowampa_bq_coeff_loader with a scripted Wishbone target.
module tb_lowampa_bq_coeff_loader;
  localparam int NC = 8;
`ifdef LOWAMPA_BQ_LOADER_READBACK_EN
  localparam int PER = 2*NC + 1;
  localparam int W7  = 2*(NC-1);
`else
  localparam int PER = NC + 1;
  localparam int W7  = NC - 1;
`endif

  logic        clk = 0, rst = 1, start = 0, cwe = 0;
  logic [7:0]  mask = 0;
  logic [2:0]  cidx = 0;
  logic [31:0] cdat = 0;
  logic        busy_o, done_o, err_o;
  logic [2:0]  err_chan_o, err_code_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [21:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        ack = 0, err = 0, rty = 0;
  logic [31:0] rdat = 0;

  always #5 clk = ~clk;

  lowampa_bq_coeff_loader dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .chan_mask_i(mask),
    .coef_we_i(cwe), .coef_idx_i(cidx), .coef_dat_i(cdat),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_chan_o(err_chan_o),
    .err_code_o(err_code_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty), .wb_dat_i(rdat));

  int vec = 0, errs = 0;
  int tn = -1, run_len = 0, done_cnt = 0, cyc_cnt = 0, unstable = 0, sel_bad = 0;
  int hang_tn = -1, rty_from = -1, rty_num = 0, errack_tn = -1, bad_tn = -1;
  logic        prev_stb = 0;
  logic [31:0] last_wdat = 0;
  logic [21:0] log_adr [64];
  logic        log_we  [64];
  logic [31:0] log_dat [64];

  // target model + bus monitor; responses are driven mid-cycle
  always @(negedge clk) begin
    ack = 0; err = 0; rty = 0; rdat = 0;
    if (done_o) done_cnt++;
    if (wb_cyc_o) cyc_cnt++;
    if (wb_stb_o) begin
      if (!prev_stb) begin
        tn++;
        run_len = 0;
        if (tn >= 0 && tn < 64) begin
          log_adr[tn] = wb_adr_o; log_we[tn] = wb_we_o; log_dat[tn] = wb_dat_o;
        end
        if (wb_we_o) last_wdat = wb_dat_o;
      end else if (tn >= 0 && tn < 64 && (wb_adr_o !== log_adr[tn] || wb_we_o !== log_we[tn] ||
                   (wb_we_o && wb_dat_o !== log_dat[tn])))
        unstable++;
      if (wb_sel_o !== 4'hF) sel_bad++;
      run_len++;
      if (tn == hang_tn) ;
      else if (tn == errack_tn) begin err = 1; ack = 1; end
      else if (tn >= rty_from && tn < rty_from + rty_num) rty = 1;
      else begin ack = 1; rdat = (tn == bad_tn) ? last_wdat ^ 32'h1 : last_wdat; end
    end
    prev_stb = wb_stb_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    tn = -1; done_cnt = 0; cyc_cnt = 0; unstable = 0; run_len = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 3000) begin @(negedge clk); n++; end
    chk("idle_bound", 32'(n < 3000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [7:0] m);
    @(negedge clk); clr(); mask = m; start = 1;
    @(negedge clk); start = 0;
    wait_idle();
  endtask

  initial begin
    logic [31:0] ea, ed;
    logic        ew;
    int          k, i;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_cyc", 32'(wb_cyc_o), 0);
    chk("rst_stb", 32'(wb_stb_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_code", 32'(err_code_o), 0);
    chk("rst_adr", 32'(wb_adr_o), 0);

    for (int j = 0; j < NC; j++) begin
      @(negedge clk); cwe = 1; cidx = 3'(j); cdat = 32'hC0DE_0000 + j;
    end
    @(negedge clk); cwe = 0;

    // two channels, full broadcast
    run(8'h05);
    chk("t1_count", 32'(tn + 1), 32'(2*PER));
    for (int c = 0; c < 2; c++)
      for (int j = 0; j < PER; j++) begin
        i = c*PER + j;
        if (j == PER-1) begin
          ea = 32'(c*2) << 10 | 32'h80; ed = 32'h1; ew = 1;
        end else begin
`ifdef LOWAMPA_BQ_LOADER_READBACK_EN
          k = j/2; ew = (j % 2 == 0);
`else
          k = j; ew = 1;
`endif
          ea = 32'(c*2) << 10 | 32'(4*k); ed = 32'hC0DE_0000 + k;
        end
        chk("t1_adr", 32'(log_adr[i]), ea);
        chk("t1_we", 32'(log_we[i]), 32'(ew));
        if (ew) chk("t1_dat", log_dat[i], ed);
      end
    chk("t1_done", 32'(done_cnt), 1);
    chk("t1_err", 32'(err_o), 0);
    chk("t1_stable", 32'(unstable), 0);
    chk("t1_sel", 32'(sel_bad), 0);

    // empty mask
    @(negedge clk); clr(); mask = 8'h00; start = 1;
    @(negedge clk); start = 0;
    chk("t2_done_hi", 32'(done_o), 1);
    chk("t2_busy_hi", 32'(busy_o), 1);
    @(negedge clk);
    chk("t2_done_lo", 32'(done_o), 0);
    chk("t2_busy_lo", 32'(busy_o), 0);
    repeat (3) @(negedge clk);
    chk("t2_nocyc", 32'(cyc_cnt), 0);
    chk("t2_done_cnt", 32'(done_cnt), 1);

    // silent target on the third transfer of channel 1
    hang_tn = 2;
    run(8'h02);
    hang_tn = -1;
    chk("t3_err", 32'(err_o), 1);
    chk("t3_code", 32'(err_code_o), 2);
    chk("t3_chan", 32'(err_chan_o), 1);
    chk("t3_stb_len", 32'(run_len), 255);
    chk("t3_count", 32'(tn + 1), 3);
    chk("t3_nodone", 32'(done_cnt), 0);

    // three retries are tolerated
    rty_from = 1; rty_num = 3;
    run(8'h01);
    chk("t4_done", 32'(done_cnt), 1);
    chk("t4_err_clr", 32'(err_o), 0);
    chk("t4_count", 32'(tn + 1), 32'(PER + 3));
    chk("t4_reissue", 32'(log_adr[4]), 32'(log_adr[1]));
    chk("t4_addr1", 32'(log_adr[1]), 32'h4);

    // fourth retry aborts
    rty_num = 4;
    run(8'h01);
    rty_from = -1; rty_num = 0;
    chk("t5_err", 32'(err_o), 1);
    chk("t5_code", 32'(err_code_o), 3);
    chk("t5_chan", 32'(err_chan_o), 0);
    chk("t5_count", 32'(tn + 1), 5);
    chk("t5_nodone", 32'(done_cnt), 0);

    // err wins over ack
    errack_tn = 4;
    run(8'h08);
    errack_tn = -1;
    chk("t6_code", 32'(err_code_o), 1);
    chk("t6_chan", 32'(err_chan_o), 3);
    chk("t6_count", 32'(tn + 1), 5);

    // start and coefficient writes while busy are ignored
    @(negedge clk); clr(); mask = 8'h80; start = 1;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    start = 1; mask = 8'hFF; cwe = 1; cidx = 3'd7; cdat = 32'hDEAD_BEEF;
    @(negedge clk); start = 0; cwe = 0;
    wait_idle();
    chk("t7_count", 32'(tn + 1), 32'(PER));
    chk("t7_done", 32'(done_cnt), 1);
    chk("t7_adr0", 32'(log_adr[0]), 32'h1C00);
    chk("t7_commit", 32'(log_adr[PER-1]), 32'h1C80);
    chk("t7_dat7", log_dat[W7], 32'hC0DE_0007);

`ifdef LOWAMPA_BQ_LOADER_READBACK_EN
    // corrupt readback of coefficient 5 on channel 7
    bad_tn = 11;
    run(8'h80);
    bad_tn = -1;
    chk("t8_code", 32'(err_code_o), 4);
    chk("t8_chan", 32'(err_chan_o), 7);
    chk("t8_count", 32'(tn + 1), 12);
    chk("t8_nodone", 32'(done_cnt), 0);
`endif

    // reset while a transfer is stalled
    hang_tn = 0;
    @(negedge clk); clr(); mask = 8'h01; start = 1;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    chk("t9_cyc_before", 32'(wb_cyc_o), 1);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("t9_cyc", 32'(wb_cyc_o), 0);
    chk("t9_busy", 32'(busy_o), 0);
    chk("t9_err", 32'(err_o), 0);
    repeat (4) @(negedge clk);
    chk("t9_nodone", 32'(done_cnt), 0);
    hang_tn = -1;

    // register file was cleared by reset
    run(8'h01);
    chk("t10_dat0", log_dat[0], 32'h0);
    chk("t10_done", 32'(done_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
